// File: rtl/seq_dect_ab_if.sv
// Symbol/detect bundle for seq_dect_ab: one 2-bit symbol {A,B} per clock in,
// one detect flag Z out.
interface seq_dect_ab_if;
  // No valid/ready: every rising clk edge with clr high consumes {A,B} as a
  // symbol, and Z reflects the registered state once that edge has passed.
  logic A;
  logic B;
  logic Z;

  modport master (output A, output B, input Z);
  modport slave (input A, input B, output Z);
endinterface

// File: rtl/seq_dect_ab.sv
// Moore detector for a SEQ_LEN-symbol pattern on the 2-bit {A,B} stream.
// State is the length of the longest pattern prefix that ends the history.
module seq_dect_ab #(
  parameter int                     SEQ_LEN = 3,
  parameter logic [2*SEQ_LEN-1:0]   PATTERN = 6'b00_11_10
) (
  input  logic          clk,
  input  logic          clr,
  seq_dect_ab_if.slave  bus,
  output logic [3:0]    state_dbg
);

  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, S8
  } state_t;

  localparam state_t SM = state_t'(4'(SEQ_LEN));

  // Symbol i of the pattern, i = 0 being the first symbol to arrive.
  function automatic int pat_sym(input int i);
    return int'(PATTERN[2*(SEQ_LEN-1-i) +: 2]);
  endfunction

  // Longest pattern prefix that is a suffix of (prefix k ++ s); evaluated at
  // elaboration only, so the runtime logic is a plain lookup.
  function automatic int kmp_next(input int k, input int s);
    int  best;
    bit  ok;
    int  idx;
    int  c;
    best = 0;
    for (int j = 1; j <= SEQ_LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) begin
          idx = k + 1 - j + t;
          c   = (idx == k) ? s : pat_sym(idx);
          if (c != pat_sym(t)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  state_t next_tbl [0:15][0:3];

  for (genvar k = 0; k < 16; k++) begin : g_k
    for (genvar s = 0; s < 4; s++) begin : g_s
      if (k <= SEQ_LEN) begin : g_live
        assign next_tbl[k][s] = state_t'(4'(kmp_next(k, s)));
      end else begin : g_dead
        assign next_tbl[k][s] = S0;
      end
    end
  end

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  sym;
  logic        sym_known;

  assign sym = {bus.A, bus.B};
  // An unknown symbol can never be part of a match, so it drops to S0.
  assign sym_known = ((^sym) !== 1'bx);

  always_comb begin
    state_d = S0;
    if (sym_known) state_d = next_tbl[state_q][sym];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S0;
    else      state_q <= state_d;
  end

  assign bus.Z     = (state_q == SM);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_dect_ab.sv
// Bench for seq_dect_ab: two instances (default pattern and 11_11_11) share one
// symbol stream; a history-based reference model feeds per-instance queues.
module tb_seq_dect_ab;

  logic        clk = 1'b1;
  logic        clr;
  logic [3:0]  dbg0;
  logic [3:0]  dbg1;

  seq_dect_ab_if bus0 ();
  seq_dect_ab_if bus1 ();

  seq_dect_ab #(.SEQ_LEN(3), .PATTERN(6'b00_11_10)) dut0 (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus0.slave),
    .state_dbg (dbg0)
  );

  seq_dect_ab #(.SEQ_LEN(3), .PATTERN(6'b11_11_11)) dut1 (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus1.slave),
    .state_dbg (dbg1)
  );

  // Rising edges at 20, 40, ...; symbols change on the falling edges.
  always #10 clk = ~clk;

  int          pat0 [3] = '{0, 3, 2};
  int          pat1 [3] = '{3, 3, 3};
  int          hist0 [$];
  int          hist1 [$];
  logic [1:0]  exp_q0 [$];   // {in_reset, z}
  logic [1:0]  exp_q1 [$];
  int          n_vec = 0;
  int          n_err = 0;

  // Expected Z straight from the definition: the last three symbols since
  // reset equal the pattern.
  function automatic logic model_z(input int h[$], input int p[3]);
    if (h.size() < 3) return 1'b0;
    for (int i = 0; i < 3; i++)
      if (h[h.size() - 3 + i] != p[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  // Drive one symbol period (called on a falling edge) and record its expectation.
  task automatic cycle(input logic [1:0] sym, input logic c);
    clr    = c;
    bus0.A = sym[1];
    bus0.B = sym[0];
    bus1.A = sym[1];
    bus1.B = sym[0];
    if (!c) begin
      hist0.delete();
      hist1.delete();
      exp_q0.push_back(2'b10);
      exp_q1.push_back(2'b10);
    end else begin
      hist0.push_back(int'(sym));
      hist1.push_back(int'(sym));
      exp_q0.push_back({1'b0, model_z(hist0, pat0)});
      exp_q1.push_back({1'b0, model_z(hist1, pat1)});
    end
    @(negedge clk);
  endtask

  task automatic stream(input logic [1:0] syms[$]);
    foreach (syms[i]) cycle(syms[i], 1'b1);
  endtask

  // Monitor: Z is a registered output, so each rising edge yields one result.
  always @(posedge clk) begin
    logic [1:0] e;
    #5;
    if (exp_q0.size() != 0) begin
      e = exp_q0.pop_front();
      check("z_pat0", {3'b0, bus0.Z}, {3'b0, e[0]});
      if (e[1]) check("state_reset_pat0", dbg0, 4'd0);
    end
    if (exp_q1.size() != 0) begin
      e = exp_q1.pop_front();
      check("z_pat1", {3'b0, bus1.Z}, {3'b0, e[0]});
      if (e[1]) check("state_reset_pat1", dbg1, 4'd0);
    end
  end

  initial begin
    logic [1:0] s;
    clr    = 1'b0;
    bus0.A = 1'b0;
    bus0.B = 1'b0;
    bus1.A = 1'b0;
    bus1.B = 1'b0;
    @(negedge clk);

    // Reset held with the inputs toggling.
    repeat (3) cycle(2'($urandom_range(0, 3)), 1'b0);

    // Mixed stream with two matches (5th and 8th symbols).
    stream('{2'b01, 2'b11, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b10});
    // Near miss.
    cycle(2'b01, 1'b0);
    stream('{2'b00, 2'b11, 2'b11, 2'b10});
    // Overlap for 11_11_11.
    stream('{2'b11, 2'b11, 2'b11, 2'b11});
    // Reset mid-match, then a clean match.
    stream('{2'b00, 2'b11});
    cycle(2'b00, 1'b0);
    stream('{2'b10, 2'b00, 2'b11, 2'b10});
    // Back-to-back matches.
    stream('{2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b10});

    // Random stream biased toward pattern symbols, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        cycle(2'($urandom_range(0, 3)), 1'b0);
      end else begin
        if ($urandom_range(0, 1) == 0) s = 2'(pat0[$urandom_range(0, 2)]);
        else                           s = 2'($urandom_range(0, 3));
        cycle(s, 1'b1);
      end
    end

    for (int i = 0; i < 10 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++)
      @(negedge clk);
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0",
               exp_q0.size(), exp_q1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
